mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive cycles fetch may lose arbitration while requesting.
REQ-002 Parameter: OST_DEPTH, default 2, max outstanding accepted requests awaiting response.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req_i  in  1 / if_addr_i  in  32  fetch read request and word address.
REQ-006 if_gnt_o  out  1 / if_rvalid_o  out  1 / if_rdata_o  out  32  fetch accept, response valid, read data.
REQ-007 d_req_i  in  1 / d_we_i  in  1 / d_size_i  in  data_size_e / d_addr_i  in  32 / d_wdata_i  in  32  data-side load/store request.
REQ-008 d_gnt_o  out  1 / d_rvalid_o  out  1 / d_rdata_o  out  32  data accept, response valid (loads and stores), read data.
REQ-009 mem_req_o  out  1 / mem_we_o  out  1 / mem_size_o  out  data_size_e / mem_addr_o  out  32 / mem_wdata_o  out  32  shared memory port request.
REQ-010 mem_gnt_i  in  1 / mem_rvalid_i  in  1 / mem_rdata_i  in  32  memory accept, in-order response.
REQ-011 err_o  out  1  sticky protocol error flag.

Function
REQ-012 Request accepted in cycle where mem_req_o && mem_gnt_i; exactly one of if_gnt_o/d_gnt_o high that cycle, matching owner.
REQ-013 FSM states IDLE, HOLD_IF, HOLD_D; IDLE selects a requester combinationally each cycle.
REQ-014 IDLE selection: data wins over fetch, unless starve counter == STARVE_LIMIT, then fetch wins.
REQ-015 IDLE -> HOLD_IF/HOLD_D when mem_req_o asserted and mem_gnt_i low; selected owner locked.
REQ-016 HOLD_x: mem_req_o stays 1, mem_* fields driven from locked requester's inputs; requester must hold request stable; -> IDLE on mem_gnt_i.
REQ-017 Starve counter: increments (saturating at STARVE_LIMIT) each cycle if_req_i high and fetch not granted; clears on if_gnt_o or if_req_i low.
REQ-018 Fetch requests drive mem_we_o=0, mem_size_o=word size, mem_wdata_o=0.
REQ-019 Owner FIFO (OST_DEPTH entries, 1 bit: 0 fetch, 1 data) pushes owner on acceptance, pops on mem_rvalid_i.
REQ-020 mem_rvalid_i routed combinationally (zero latency) to head owner's rvalid; mem_rdata_i copied to that rdata, other rdata driven 0.
REQ-021 FIFO full: mem_req_o=0 and no grant, except same-cycle mem_rvalid_i pop allows issue (pop-then-push).
REQ-022 FIFO full with FSM in HOLD_x: mem_req_o dropped until space; lock retained.
REQ-023 mem_rvalid_i with FIFO empty: err_o set, no rvalid forwarded, FIFO unchanged.
REQ-024 No requests: mem_req_o=0, mem_* fields 0, FSM IDLE.
REQ-025 Responses delivered in acceptance order; no reordering.

Reset
REQ-026 On rst_n low: FSM IDLE, FIFO empty, starve counter 0, err_o 0; all grant/valid outputs 0 while reset asserted.
REQ-027 Reset mid-transaction discards outstanding ownership; subsequent mem_rvalid_i before new acceptance flags err_o.

Structure
REQ-028 data_size_e reused from the shared package; arb_state_e and owner encoding added to that package.
REQ-029 Owner FIFO implemented as sub-module owner_fifo (parameterised depth, 1-bit data, full/empty, simultaneous push/pop).

Verification
REQ-030 Both request same cycle, mem_gnt_i=1, FIFO empty -> d_gnt_o=1, mem_addr_o=d_addr_i, if_gnt_o=0.
REQ-031 Fetch and data request continuously 5 cycles, mem_gnt_i=1, rvalid every cycle -> fetch granted on 5th cycle (starve counter hit 4).
REQ-032 Fetch selected, mem_gnt_i=0 3 cycles, d_req_i rises cycle 2 -> mem_addr_o stays if_addr_i until grant; data granted after.
REQ-033 Accept fetch(0x100), data load(0x200), mem_rvalid_i returns 0xAAAA then 0xBBBB -> if_rvalid_o/0xAAAA then d_rvalid_o/0xBBBB.
REQ-034 Two accepted, no response, requests pending -> mem_req_o=0; mem_rvalid_i pulse -> issue same cycle, FIFO stays full.
REQ-035 mem_rvalid_i after reset with no acceptance -> err_o=1, held until rst_n low.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory arbiter slice.
// data_size_e : access size carried on data and memory ports
// arb_state_e : arbiter FSM states
// owner_e     : owner tag stored per outstanding request (0 fetch, 1 data)
package mem_arbiter_pkg;
    typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} data_size_e;
    typedef enum logic [1:0] {IDLE, HOLD_IF, HOLD_D} arb_state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of fetch, data and memory-port signals around the arbiter.
// master : arbiter view (takes fetch/data requests and memory responses, drives grants and memory requests)
// slave  : environment view (requesters and memory)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    data_size_e  d_size_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    data_size_e  mem_size_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    modport master (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o, err_o
    );
    modport slave (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o, err_o
    );
endinterface

// File: rtl/owner_fifo.sv
// owner_fifo: DEPTH-entry 1-bit FIFO recording the owner of each outstanding request.
// clk, rst_n : clock, asynchronous active-low reset
// push, din  : write owner bit (allowed when full only together with pop)
// pop        : drop head entry (caller guarantees not empty)
// dout       : head owner bit; full, empty : occupancy flags
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) mem[wp] <= din;
            if (push) wp <= inc(wp);
            if (pop) rp <= inc(rp);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one in-order memory port between a fetch and a data requester.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : mem_arbiter_if.master carrying fetch/data requests and responses,
//              the shared memory request port and the sticky err_o flag
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int OST_DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    arb_state_e    state;
    logic [SW-1:0] starve;
    logic          head, full, empty;
    logic          fetch_pri, is_d, want, pop, issue, accept;
    // Data normally wins in IDLE; a fetch that has lost STARVE_LIMIT times in a row wins instead.
    assign fetch_pri = bus.if_req_i && starve == SW'(STARVE_LIMIT);
    assign is_d      = state == HOLD_D || (state == IDLE && bus.d_req_i && !fetch_pri);
    assign want      = state != IDLE || bus.if_req_i || bus.d_req_i;
    // A response only pops when something is outstanding; the pop frees a slot for a same-cycle issue.
    assign pop    = rst_n && bus.mem_rvalid_i && !empty;
    assign issue  = rst_n && want && (!full || pop);
    assign accept = issue && bus.mem_gnt_i;
    assign bus.mem_req_o   = issue;
    assign bus.mem_we_o    = want && is_d && bus.d_we_i;
    assign bus.mem_size_o  = !want ? SIZE_BYTE : is_d ? bus.d_size_i : SIZE_WORD;
    assign bus.mem_addr_o  = !want ? '0 : is_d ? bus.d_addr_i : bus.if_addr_i;
    assign bus.mem_wdata_o = want && is_d ? bus.d_wdata_i : '0;
    assign bus.if_gnt_o    = accept && !is_d;
    assign bus.d_gnt_o     = accept && is_d;
    assign bus.if_rvalid_o = pop && !head;
    assign bus.d_rvalid_o  = pop && head;
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_rdata_i : '0;
    owner_fifo #(.DEPTH(OST_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .din   (is_d),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // An issued but ungranted request locks its owner until the memory accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            starve    <= '0;
            bus.err_o <= 1'b0;
        end else begin
            state     <= accept ? IDLE : (state == IDLE && issue) ? (is_d ? HOLD_D : HOLD_IF) : state;
            starve    <= (!bus.if_req_i || bus.if_gnt_o) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + SW'(1);
            bus.err_o <= bus.err_o || (bus.mem_rvalid_i && empty);
        end
    end
endmodule
